hdr_mode_sequencer: RTL and testbench

HDR_MODE_SEQUENCER -- requirements
Module: hdr_mode_sequencer

---
 rtl/hdr_mode_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_hdr_mode_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/hdr_mode_sequencer.sv
// rtl/hdr_mode_sequencer.sv - HDR sub-engine sequencer with restart, dummy CCC phase and watchdog
module hdr_mode_sequencer #(
  parameter int NUM_ENG    = 4,
  parameter int SEL_W      = 2,
  parameter int ADDR_W     = 12,
  parameter int IDLE_ADDR  = 1000,
  parameter int DUMMY_ADDR = 450,
  parameter int TMO_W      = 16,
  parameter int HDR_MODE   = 6
) (
  input  logic                i_sys_clk,
  input  logic                i_sys_rst,
  input  logic                i_en,
  input  logic [SEL_W-1:0]    i_eng_sel,
  input  logic                i_toc,
  input  logic [2:0]          i_mode,
  input  logic [NUM_ENG-1:0]  i_eng_done,
  input  logic [TMO_W-1:0]    i_tmo_limit,
  output logic [NUM_ENG-1:0]  o_eng_en,
  output logic [SEL_W-1:0]    o_mux_sel,
  output logic [ADDR_W-1:0]   o_regf_addr_special,
  output logic                o_done,
  output logic [1:0]          o_err_code,
  output logic                o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DUMMY} state_t;

  localparam logic [ADDR_W-1:0] A_IDLE  = ADDR_W'(IDLE_ADDR);
  localparam logic [ADDR_W-1:0] A_DUMMY = ADDR_W'(DUMMY_ADDR);
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_TMO  = 2'b01;
  localparam logic [1:0] ERR_SEL  = 2'b10;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   cur_sel, cur_sel_nxt, pend_sel, pend_sel_nxt;
  logic               cur_toc, cur_toc_nxt;
  logic [2:0]         cur_mode, cur_mode_nxt;
  logic [TMO_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [NUM_ENG-1:0] eng_en_nxt;
  logic [SEL_W-1:0]   mux_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               done_nxt, busy_nxt, done_cur, expire;
  logic [1:0]         err_nxt;

  function automatic logic [NUM_ENG-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [NUM_ENG-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_ENG; i++)
      if (s == SEL_W'(i)) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic bad_sel(input logic [SEL_W-1:0] s);
    return 32'(s) >= NUM_ENG;
  endfunction

  // Done from the engine currently owning the shared resources; other bits are ignored.
  assign done_cur = |(i_eng_done & onehot(cur_sel));
  assign expire   = (i_tmo_limit != '0) && (cnt == i_tmo_limit - TMO_W'(1));
  assign cnt_inc  = (&cnt) ? cnt : cnt + TMO_W'(1);

  // State register and registered outputs; reset overrides everything.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state               <= S_IDLE;
      cur_sel             <= '0;
      pend_sel            <= '0;
      cur_toc             <= 1'b0;
      cur_mode            <= '0;
      cnt                 <= '0;
      o_eng_en            <= '0;
      o_mux_sel           <= '0;
      o_regf_addr_special <= A_IDLE;
      o_done              <= 1'b0;
      o_err_code          <= ERR_NONE;
      o_busy              <= 1'b0;
    end else begin
      state               <= state_nxt;
      cur_sel             <= cur_sel_nxt;
      pend_sel            <= pend_sel_nxt;
      cur_toc             <= cur_toc_nxt;
      cur_mode            <= cur_mode_nxt;
      cnt                 <= cnt_nxt;
      o_eng_en            <= eng_en_nxt;
      o_mux_sel           <= mux_nxt;
      o_regf_addr_special <= addr_nxt;
      o_done              <= done_nxt;
      o_err_code          <= err_nxt;
      o_busy              <= busy_nxt;
    end
  end

  // Next-state and next-output decode; abort beats done, done beats watchdog.
  always_comb begin
    state_nxt    = state;
    cur_sel_nxt  = cur_sel;
    pend_sel_nxt = pend_sel;
    cur_toc_nxt  = cur_toc;
    cur_mode_nxt = cur_mode;
    cnt_nxt      = cnt;
    eng_en_nxt   = '0;
    mux_nxt      = o_mux_sel;
    addr_nxt     = A_IDLE;
    done_nxt     = 1'b0;
    err_nxt      = o_err_code;
    case (state)
      S_IDLE: begin
        if (i_en) begin
          cur_sel_nxt  = i_eng_sel;
          cur_toc_nxt  = i_toc;
          cur_mode_nxt = i_mode;
          err_nxt      = ERR_NONE;
          if (bad_sel(i_eng_sel)) begin
            err_nxt  = ERR_SEL;
            done_nxt = 1'b1;
          end else begin
            state_nxt  = S_RUN;
            eng_en_nxt = onehot(i_eng_sel);
            mux_nxt    = i_eng_sel;
            cnt_nxt    = '0;
          end
        end
      end
      S_RUN: begin
        if (!i_en) begin
          state_nxt = S_IDLE;
        end else if (done_cur) begin
          if (cur_toc || (cur_mode != 3'(HDR_MODE))) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            pend_sel_nxt = i_eng_sel;
            cur_toc_nxt  = i_toc;
            cur_mode_nxt = i_mode;
            if ((cur_sel == '0) && (i_eng_sel != '0)) begin
              state_nxt  = S_DUMMY;
              eng_en_nxt = NUM_ENG'(1);
              mux_nxt    = '0;
              addr_nxt   = A_DUMMY;
              cnt_nxt    = '0;
            end else begin
              state_nxt = S_GAP;
            end
          end
        end else if (expire) begin
          state_nxt = S_IDLE;
          err_nxt   = ERR_TMO;
          done_nxt  = 1'b1;
        end else begin
          eng_en_nxt = o_eng_en;
          cnt_nxt    = cnt_inc;
        end
      end
      S_GAP: begin
        if (!i_en) begin
          state_nxt = S_IDLE;
        end else begin
          cur_sel_nxt = pend_sel;
          if (bad_sel(pend_sel)) begin
            state_nxt = S_IDLE;
            err_nxt   = ERR_SEL;
            done_nxt  = 1'b1;
          end else begin
            state_nxt  = S_RUN;
            eng_en_nxt = onehot(pend_sel);
            mux_nxt    = pend_sel;
            cnt_nxt    = '0;
          end
        end
      end
      S_DUMMY: begin
        if (!i_en) begin
          state_nxt = S_IDLE;
        end else if (i_eng_done[0]) begin
          state_nxt = S_GAP;
        end else if (expire) begin
          state_nxt = S_IDLE;
          err_nxt   = ERR_TMO;
          done_nxt  = 1'b1;
        end else begin
          eng_en_nxt = NUM_ENG'(1);
          addr_nxt   = A_DUMMY;
          cnt_nxt    = cnt_inc;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_hdr_mode_sequencer.sv
// tb/tb_hdr_mode_sequencer.sv - directed scoreboard bench for hdr_mode_sequencer
module tb_hdr_mode_sequencer;

  localparam logic [11:0] AI = 12'd1000;
  localparam logic [11:0] AD = 12'd450;

  logic        clk = 1'b0;
  logic        rst, en, toc;
  logic [2:0]  sel, mode;
  logic [3:0]  eng_done;
  logic [15:0] lim;
  logic [3:0]  eng_en;
  logic [2:0]  mux_sel;
  logic [11:0] addr;
  logic        done, busy;
  logic [1:0]  err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [22:0] v;
  } exp_t;
  exp_t sb[$];

  hdr_mode_sequencer #(.NUM_ENG(4), .SEL_W(3)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_en(en), .i_eng_sel(sel),
    .i_toc(toc), .i_mode(mode), .i_eng_done(eng_done), .i_tmo_limit(lim),
    .o_eng_en(eng_en), .o_mux_sel(mux_sel), .o_regf_addr_special(addr),
    .o_done(done), .o_err_code(err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Push expectation for the coming edge, advance one cycle, then pop and compare.
  task automatic tick(input string tag, input logic [3:0] e_eng, input logic [2:0] e_mux,
                      input logic [11:0] e_addr, input logic e_done, input logic [1:0] e_err,
                      input logic e_busy);
    exp_t e;
    logic [22:0] obs;
    e.tag = tag;
    e.v = {e_eng, e_mux, e_addr, e_done, e_err, e_busy};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    obs = {eng_en, mux_sel, addr, done, err, busy};
    checks++;
    assert (obs === e.v) else begin
      failures++;
      $error("FAIL %s observed eng=%b mux=%0d addr=%0d done=%b err=%b busy=%b expected {eng,mux,addr,done,err,busy}=%h got %h",
             e.tag, eng_en, mux_sel, addr, done, err, busy, e.v, obs);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; toc = 1'b0; sel = '0; mode = '0; eng_done = '0; lim = '0;
    tick("reset0", 4'b0000, 3'd0, AI, 1'b0, 2'b00, 1'b0);
    tick("reset1", 4'b0000, 3'd0, AI, 1'b0, 2'b00, 1'b0);
    rst = 1'b0;
    tick("idle", 4'b0000, 3'd0, AI, 1'b0, 2'b00, 1'b0);

    // Single transaction on engine 1, five cycles of enable, stray done bits ignored.
    en = 1'b1; sel = 3'd1; toc = 1'b1; mode = 3'd6;
    tick("t1_entry", 4'b0010, 3'd1, AI, 1'b0, 2'b00, 1'b1);
    sel = 3'd3; eng_done = 4'b0101;
    tick("t1_run2_stray", 4'b0010, 3'd1, AI, 1'b0, 2'b00, 1'b1);
    eng_done = 4'b0000;
    tick("t1_run3", 4'b0010, 3'd1, AI, 1'b0, 2'b00, 1'b1);
    tick("t1_run4", 4'b0010, 3'd1, AI, 1'b0, 2'b00, 1'b1);
    tick("t1_run5", 4'b0010, 3'd1, AI, 1'b0, 2'b00, 1'b1);
    eng_done = 4'b0010;
    tick("t1_done", 4'b0000, 3'd1, AI, 1'b1, 2'b00, 1'b0);
    en = 1'b0; eng_done = 4'b0000;
    tick("t1_after", 4'b0000, 3'd1, AI, 1'b0, 2'b00, 1'b0);

    // Restart from CCC engine to engine 2 via dummy phase and gap.
    en = 1'b1; sel = 3'd0; toc = 1'b0; mode = 3'd6;
    tick("t2_entry", 4'b0001, 3'd0, AI, 1'b0, 2'b00, 1'b1);
    sel = 3'd2; toc = 1'b1; eng_done = 4'b0001;
    tick("t2_dummy", 4'b0001, 3'd0, AD, 1'b0, 2'b00, 1'b1);
    eng_done = 4'b0000;
    tick("t2_dummy2", 4'b0001, 3'd0, AD, 1'b0, 2'b00, 1'b1);
    eng_done = 4'b0001;
    tick("t2_gap", 4'b0000, 3'd0, AI, 1'b0, 2'b00, 1'b1);
    eng_done = 4'b0000;
    tick("t2_run", 4'b0100, 3'd2, AI, 1'b0, 2'b00, 1'b1);
    tick("t2_run2", 4'b0100, 3'd2, AI, 1'b0, 2'b00, 1'b1);
    eng_done = 4'b0100;
    tick("t2_done", 4'b0000, 3'd2, AI, 1'b1, 2'b00, 1'b0);
    en = 1'b0; eng_done = 4'b0000;
    tick("t2_after", 4'b0000, 3'd2, AI, 1'b0, 2'b00, 1'b0);

    // Same-engine restart still passes through one gap cycle.
    en = 1'b1; sel = 3'd1; toc = 1'b0; mode = 3'd6;
    tick("t3_entry", 4'b0010, 3'd1, AI, 1'b0, 2'b00, 1'b1);
    toc = 1'b1; eng_done = 4'b0010;
    tick("t3_gap", 4'b0000, 3'd1, AI, 1'b0, 2'b00, 1'b1);
    eng_done = 4'b0000;
    tick("t3_run", 4'b0010, 3'd1, AI, 1'b0, 2'b00, 1'b1);
    eng_done = 4'b0010;
    tick("t3_done", 4'b0000, 3'd1, AI, 1'b1, 2'b00, 1'b0);
    eng_done = 4'b0000; en = 1'b0;
    tick("t3_after", 4'b0000, 3'd1, AI, 1'b0, 2'b00, 1'b0);

    // Non-HDR mode with toc=0 exits instead of restarting.
    en = 1'b1; sel = 3'd3; toc = 1'b0; mode = 3'd3;
    tick("t4_entry", 4'b1000, 3'd3, AI, 1'b0, 2'b00, 1'b1);
    eng_done = 4'b1000; mode = 3'd6;
    tick("t4_done", 4'b0000, 3'd3, AI, 1'b1, 2'b00, 1'b0);
    eng_done = 4'b0000; en = 1'b0;
    tick("t4_after", 4'b0000, 3'd3, AI, 1'b0, 2'b00, 1'b0);

    // Watchdog limit 8: eight cycles of enable then timeout, error sticky.
    lim = 16'd8; en = 1'b1; sel = 3'd2; toc = 1'b1; mode = 3'd6;
    tick("t5_entry", 4'b0100, 3'd2, AI, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 7; i++)
      tick("t5_run", 4'b0100, 3'd2, AI, 1'b0, 2'b00, 1'b1);
    tick("t5_tmo", 4'b0000, 3'd2, AI, 1'b1, 2'b01, 1'b0);
    en = 1'b0;
    tick("t5_sticky", 4'b0000, 3'd2, AI, 1'b0, 2'b01, 1'b0);

    // Done coinciding with watchdog expiry: done wins, error cleared on start.
    lim = 16'd2; en = 1'b1; sel = 3'd1;
    tick("t6_entry", 4'b0010, 3'd1, AI, 1'b0, 2'b00, 1'b1);
    tick("t6_run", 4'b0010, 3'd1, AI, 1'b0, 2'b00, 1'b1);
    eng_done = 4'b0010;
    tick("t6_done_wins", 4'b0000, 3'd1, AI, 1'b1, 2'b00, 1'b0);
    eng_done = 4'b0000; en = 1'b0; lim = 16'd0;
    tick("t6_after", 4'b0000, 3'd1, AI, 1'b0, 2'b00, 1'b0);

    // Abort concurrent with done: no completion pulse.
    en = 1'b1; sel = 3'd1; toc = 1'b1;
    tick("t7_entry", 4'b0010, 3'd1, AI, 1'b0, 2'b00, 1'b1);
    tick("t7_run", 4'b0010, 3'd1, AI, 1'b0, 2'b00, 1'b1);
    en = 1'b0; eng_done = 4'b0010;
    tick("t7_abort", 4'b0000, 3'd1, AI, 1'b0, 2'b00, 1'b0);
    eng_done = 4'b0000;
    tick("t7_after", 4'b0000, 3'd1, AI, 1'b0, 2'b00, 1'b0);

    // Out-of-range select.
    en = 1'b1; sel = 3'd5;
    tick("t8_badsel", 4'b0000, 3'd1, AI, 1'b1, 2'b10, 1'b0);
    en = 1'b0;
    tick("t8_sticky", 4'b0000, 3'd1, AI, 1'b0, 2'b10, 1'b0);

    // Reset while in the dummy phase.
    en = 1'b1; sel = 3'd0; toc = 1'b0; mode = 3'd6;
    tick("t9_entry", 4'b0001, 3'd0, AI, 1'b0, 2'b00, 1'b1);
    sel = 3'd3; eng_done = 4'b0001;
    tick("t9_dummy", 4'b0001, 3'd0, AD, 1'b0, 2'b00, 1'b1);
    rst = 1'b1; eng_done = 4'b0000;
    tick("t9_reset", 4'b0000, 3'd0, AI, 1'b0, 2'b00, 1'b0);
    tick("t9_reset_hold", 4'b0000, 3'd0, AI, 1'b0, 2'b00, 1'b0);
    rst = 1'b0; en = 1'b0;
    tick("t9_idle", 4'b0000, 3'd0, AI, 1'b0, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
